// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind spi_slave: executes WRITE/READ/TRIGGER/CLEAR packets against a
// bank of 24-bit config registers. Define SPI_CMD_TIMEOUT_EN to bound the wait for i_resp_ack.
module spi_cmd_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int RESP_TIMEOUT = 1000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_packet_received,
    input  logic [39:0]            i_packet_data,
    output logic [NUM_REGS*24-1:0] o_cfg_regs,
    output logic                   o_trig,
    output logic [31:0]            o_resp_data,
    output logic                   o_resp_valid,
    input  logic                   i_resp_ack,
    output logic                   o_busy,
    output logic [7:0]             o_err_count,
    output logic [7:0]             o_drop_count,
    output logic                   o_LED
);

    if (NUM_REGS < 1 || NUM_REGS > 255 || RESP_TIMEOUT < 1) begin : g_param_check
        $error("spi_cmd_ctrl: NUM_REGS must be 1..255 and RESP_TIMEOUT at least 1");
    end

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_TRIGGER = 8'h03;
    localparam logic [7:0] CMD_CLEAR   = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        pkt_prev_reg;
    logic [7:0]  cmd_reg, cmd_next;
    logic [7:0]  addr_reg, addr_next;
    logic [23:0] data_reg, data_next;
    logic        trig_reg, trig_next;
    logic [31:0] resp_data_reg, resp_data_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [7:0]  err_count_reg, err_count_next;
    logic [7:0]  drop_count_reg, drop_count_next;
    logic        led_reg, led_next;

    logic        rise;
    logic        addr_ok;
    logic        write_en;
    logic        clear_en;
    logic [23:0] rd_value;

`ifdef SPI_CMD_TIMEOUT_EN
    // Counts RESP cycles 0..RESP_TIMEOUT-1; the last value is the final chance for an ack.
    localparam int TIMER_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RESP_TIMEOUT - 1);
    logic [TIMER_W-1:0] timer_reg, timer_next;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    assign rise    = i_packet_received & ~pkt_prev_reg;
    assign addr_ok = int'({24'd0, addr_reg}) < NUM_REGS;

    // Register bank: each entry decodes its own address so CLEAR can zero all in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
            logic [23:0] value_reg;
            always_ff @(posedge i_clk) begin
                if (i_rst || clear_en) begin
                    value_reg <= '0;
                end else if (write_en && addr_reg == 8'(gi)) begin
                    value_reg <= data_reg;
                end
            end
            assign o_cfg_regs[24*gi +: 24] = value_reg;
        end
    endgenerate

    always_comb begin
        rd_value = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_reg == 8'(k)) begin
                rd_value = o_cfg_regs[24*k +: 24];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        trig_next       = 1'b0;
        resp_data_next  = resp_data_reg;
        resp_valid_next = resp_valid_reg;
        err_count_next  = err_count_reg;
        drop_count_next = drop_count_reg;
        led_next        = led_reg;
        write_en        = 1'b0;
        clear_en        = 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
        timer_next      = timer_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    cmd_next   = i_packet_data[39:32];
                    addr_next  = i_packet_data[31:24];
                    data_next  = i_packet_data[23:0];
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_next = ST_IDLE;
                if (rise) begin
                    drop_count_next = sat_inc(drop_count_reg);
                end
                case (cmd_reg)
                    CMD_WRITE: begin
                        if (addr_ok) begin
                            write_en = 1'b1;
                            led_next = ~led_reg;
                        end else begin
                            err_count_next = sat_inc(err_count_reg);
                        end
                    end
                    CMD_READ: begin
                        if (addr_ok) begin
                            resp_data_next  = {addr_reg, rd_value};
                            resp_valid_next = 1'b1;
                            led_next        = ~led_reg;
                            state_next      = ST_RESP;
`ifdef SPI_CMD_TIMEOUT_EN
                            timer_next      = '0;
`endif
                        end else begin
                            err_count_next = sat_inc(err_count_reg);
                        end
                    end
                    CMD_TRIGGER: begin
                        trig_next = 1'b1;
                        led_next  = ~led_reg;
                    end
                    CMD_CLEAR: begin
                        clear_en = 1'b1;
                        led_next = ~led_reg;
                    end
                    default: begin
                        err_count_next = sat_inc(err_count_reg);
                    end
                endcase
            end

            ST_RESP: begin
                // A packet arriving while a response is pending is lost, even on the ack edge.
                if (rise) begin
                    drop_count_next = sat_inc(drop_count_reg);
                end
                if (i_resp_ack) begin
                    resp_valid_next = 1'b0;
                    state_next      = ST_IDLE;
                end
`ifdef SPI_CMD_TIMEOUT_EN
                else if (timer_reg == TIMER_LAST) begin
                    resp_valid_next = 1'b0;
                    err_count_next  = sat_inc(err_count_reg);
                    state_next      = ST_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
`endif
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            pkt_prev_reg   <= 1'b0;
            cmd_reg        <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            trig_reg       <= 1'b0;
            resp_data_reg  <= '0;
            resp_valid_reg <= 1'b0;
            err_count_reg  <= '0;
            drop_count_reg <= '0;
            led_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pkt_prev_reg   <= i_packet_received;
            cmd_reg        <= cmd_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            trig_reg       <= trig_next;
            resp_data_reg  <= resp_data_next;
            resp_valid_reg <= resp_valid_next;
            err_count_reg  <= err_count_next;
            drop_count_reg <= drop_count_next;
            led_reg        <= led_next;
        end
    end

`ifdef SPI_CMD_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`endif

    assign o_trig       = trig_reg;
    assign o_resp_data  = resp_data_reg;
    assign o_resp_valid = resp_valid_reg;
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_err_count  = err_count_reg;
    assign o_drop_count = drop_count_reg;
    assign o_LED        = led_reg;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: random packets checked against a behavioural register-bank model.
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;
    localparam int NUM_REGS     = 8;
    localparam int RESP_TIMEOUT = 10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   pkt_rcv = 1'b0;
    logic [39:0]            pkt_data = '0;
    logic                   resp_ack = 1'b0;
    logic [NUM_REGS*24-1:0] cfg_regs;
    logic                   trig;
    logic [31:0]            resp_data;
    logic                   resp_valid;
    logic                   busy;
    logic [7:0]             err_count;
    logic [7:0]             drop_count;
    logic                   led;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [23:0] m_regs [NUM_REGS];
    int          m_err;
    int          m_drop;
    logic        m_led;

    spi_cmd_ctrl #(.NUM_REGS(NUM_REGS), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_packet_received (pkt_rcv),
        .i_packet_data     (pkt_data),
        .o_cfg_regs        (cfg_regs),
        .o_trig            (trig),
        .o_resp_data       (resp_data),
        .o_resp_valid      (resp_valid),
        .i_resp_ack        (resp_ack),
        .o_busy            (busy),
        .o_err_count       (err_count),
        .o_drop_count      (drop_count),
        .o_LED             (led)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [NUM_REGS*24-1:0] m_flat();
        logic [NUM_REGS*24-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_REGS; k++) f[24*k +: 24] = m_regs[k];
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        m_err = 0;
        m_drop = 0;
        m_led = 1'b0;
    endtask

    // Applies one executed command to the model; reports whether a response/trigger is expected.
    task automatic model_exec(input logic [7:0] c, input logic [7:0] a, input logic [23:0] d,
                              output bit is_read, output logic [31:0] resp, output bit is_trig);
        bit ok;
        int ai;
        ai = int'(a);
        ok = 1'b1;
        is_read = 1'b0;
        is_trig = 1'b0;
        resp = '0;
        if (c == 8'h01 && ai < NUM_REGS) begin
            m_regs[ai] = d;
        end else if (c == 8'h02 && ai < NUM_REGS) begin
            is_read = 1'b1;
            resp = {a, m_regs[ai]};
        end else if (c == 8'h03) begin
            is_trig = 1'b1;
        end else if (c == 8'h04) begin
            for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        end else begin
            ok = 1'b0;
        end
        if (ok) m_led = ~m_led;
        else if (m_err < 255) m_err++;
    endtask

    // Called at a negedge: presents a one-cycle packet pulse; returns at the next negedge.
    task automatic drive_packet(input logic [39:0] pkt);
        pkt_data = pkt;
        pkt_rcv = 1'b1;
        @(negedge clk);
        pkt_rcv = 1'b0;
    endtask

    // Packet plus the EXEC cycle; returns when the command's effect is visible.
    task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [23:0] d,
                          output bit is_read, output logic [31:0] resp, output bit is_trig);
        drive_packet({c, a, d});
        @(negedge clk);
        model_exec(c, a, d, is_read, resp, is_trig);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pkt_rcv = 1'b1;
        resp_ack = 1'b1;
        repeat (3) @(negedge clk);
        pkt_rcv = 1'b0;
        resp_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL reset_regs: got %h expected %h", cfg_regs, m_flat()); end
        checks++; if ({trig, resp_valid, busy, led} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {trig, resp_valid, busy, led}); end
        checks++; if ({err_count, drop_count} !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h expected 0000", {err_count, drop_count}); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    endtask

    task automatic test_write();
        bit rd, tg;
        logic [31:0] rsp;
        drive_packet({8'h01, 8'h02, 24'hABCDEF});
        checks++; if (cfg_regs[48 +: 24] !== 24'h0) begin errors++; $display("FAIL write_early: got %h expected 000000", cfg_regs[48 +: 24]); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
        @(negedge clk);
        model_exec(8'h01, 8'h02, 24'hABCDEF, rd, rsp, tg);
        checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL write_regs: got %h expected %h", cfg_regs, m_flat()); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL write_led: got %b expected 1", led); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL write_err: got %0d expected 0", err_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        bit rd, tg;
        logic [31:0] rsp;
        do_cmd(8'h01, 8'h05, 24'h123456, rd, rsp, tg);
        do_cmd(8'h02, 8'h05, 24'h000000, rd, rsp, tg);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_data !== 32'h05123456) begin errors++; $display("FAIL read_data: got %h expected 05123456", resp_data); end
        repeat (3) begin
            @(negedge clk);
            checks++; if ({resp_valid, busy} !== 2'b11 || resp_data !== rsp) begin errors++; $display("FAIL read_hold: got v=%b b=%b d=%h expected v=1 b=1 d=%h", resp_valid, busy, resp_data, rsp); end
        end
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
        checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL read_ack_drop: got v=%b b=%b expected 00", resp_valid, busy); end
        resp_ack = 1'b1;
        repeat (2) @(negedge clk);
        resp_ack = 1'b0;
        checks++; if ({resp_valid, busy} !== 2'b00 || cfg_regs !== m_flat()) begin errors++; $display("FAIL idle_ack_ignored: got v=%b b=%b regs=%h", resp_valid, busy, cfg_regs); end
    endtask

    task automatic test_trigger_clear();
        bit rd, tg;
        logic [31:0] rsp;
        drive_packet({8'h03, 8'h00, 24'h000000});
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL trig_early: got %b expected 0", trig); end
        @(negedge clk);
        model_exec(8'h03, 8'h00, 24'h000000, rd, rsp, tg);
        checks++; if (trig !== tg) begin errors++; $display("FAIL trig_pulse: got %b expected %b", trig, tg); end
        @(negedge clk);
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL trig_width: got %b expected 0", trig); end
        do_cmd(8'h01, 8'h07, 24'($urandom), rd, rsp, tg);
        do_cmd(8'h04, 8'h00, 24'h000000, rd, rsp, tg);
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL clear_regs: got %h expected 0", cfg_regs); end
        checks++; if (led !== m_led) begin errors++; $display("FAIL clear_led: got %b expected %b", led, m_led); end
    endtask

    task automatic test_errors();
        bit rd, tg;
        logic [31:0] rsp;
        logic led_before;
        led_before = led;
        do_cmd(8'h7F, 8'h00, 24'h000000, rd, rsp, tg);
        do_cmd(8'h01, 8'h08, 24'h000001, rd, rsp, tg);
        checks++; if (err_count !== 8'd2 || int'(err_count) != m_err) begin errors++; $display("FAIL err_count: got %0d expected %0d", err_count, m_err); end
        checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL err_no_write: got %h expected %h", cfg_regs, m_flat()); end
        checks++; if (led !== led_before) begin errors++; $display("FAIL err_led: got %b expected %b", led, led_before); end
    endtask

    task automatic test_drop();
        bit rd, tg;
        logic [31:0] rsp;
        do_cmd(8'h02, 8'h03, 24'h000000, rd, rsp, tg);
        drive_packet({8'h01, 8'h00, 24'h000011});
        m_drop++;
        @(negedge clk);
        checks++; if (int'(drop_count) != m_drop) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drop); end
        checks++; if (cfg_regs !== m_flat() || resp_valid !== 1'b1) begin errors++; $display("FAIL drop_no_exec: got v=%b regs=%h expected v=1 regs=%h", resp_valid, cfg_regs, m_flat()); end
        pkt_data = {8'h01, 8'h00, 24'h000011};
        pkt_rcv = 1'b1;
        resp_ack = 1'b1;
        @(negedge clk);
        pkt_rcv = 1'b0;
        resp_ack = 1'b0;
        m_drop++;
        checks++; if (int'(drop_count) != m_drop || resp_valid !== 1'b0) begin errors++; $display("FAIL drop_on_ack: got drop=%0d v=%b expected drop=%0d v=0", drop_count, resp_valid, m_drop); end
        @(negedge clk);
        checks++; if (cfg_regs !== m_flat() || busy !== 1'b0) begin errors++; $display("FAIL drop_on_ack_exec: got busy=%b regs=%h expected regs=%h", busy, cfg_regs, m_flat()); end
        do_cmd(8'h01, 8'h00, 24'h000011, rd, rsp, tg);
        checks++; if (cfg_regs[23:0] !== 24'h000011 || cfg_regs !== m_flat()) begin errors++; $display("FAIL resend: got %h expected %h", cfg_regs, m_flat()); end
    endtask

    task automatic test_back_to_back();
        bit rd, tg;
        logic [31:0] rsp;
        logic [7:0] a;
        logic [23:0] d;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, NUM_REGS - 1));
            d = 24'($urandom);
            do_cmd(8'h01, a, d, rd, rsp, tg);
        end
        checks++; if (cfg_regs !== m_flat() || led !== m_led) begin errors++; $display("FAIL b2b_writes: got led=%b regs=%h expected led=%b regs=%h", led, cfg_regs, m_led, m_flat()); end
        // A level held for several cycles is a single packet.
        pkt_data = {8'h01, 8'h06, 24'h5A5A5A};
        pkt_rcv = 1'b1;
        repeat (4) @(negedge clk);
        pkt_rcv = 1'b0;
        model_exec(8'h01, 8'h06, 24'h5A5A5A, rd, rsp, tg);
        @(negedge clk);
        checks++; if (cfg_regs !== m_flat() || led !== m_led) begin errors++; $display("FAIL held_level: got led=%b regs=%h expected led=%b regs=%h", led, cfg_regs, m_led, m_flat()); end
    endtask

    task automatic test_random();
        bit rd, tg;
        logic [31:0] rsp;
        logic [7:0] c, a;
        logic [23:0] d;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 2) c = 8'h01;
            else if (r <= 5) c = 8'h02;
            else if (r == 6) c = 8'h03;
            else if (r == 7) c = 8'h04;
            else if (r == 8) c = 8'h00;
            else c = 8'($urandom_range(5, 255));
            a = 8'($urandom_range(0, NUM_REGS + 1));
            d = 24'($urandom);
            drive_packet({c, a, d});
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected 1", i, busy); end
            @(negedge clk);
            model_exec(c, a, d, rd, rsp, tg);
            $display("txn %0d cmd=%02h addr=%02h data=%06h read=%0d", i, c, a, d, rd);
            checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL rnd_regs[%0d]: got %h expected %h", i, cfg_regs, m_flat()); end
            checks++; if (led !== m_led || int'(err_count) != m_err) begin errors++; $display("FAIL rnd_led_err[%0d]: got led=%b err=%0d expected led=%b err=%0d", i, led, err_count, m_led, m_err); end
            checks++; if (trig !== tg || resp_valid !== rd) begin errors++; $display("FAIL rnd_trig_valid[%0d]: got t=%b v=%b expected t=%b v=%b", i, trig, resp_valid, tg, rd); end
            if (rd) begin
                checks++; if (resp_data !== rsp) begin errors++; $display("FAIL rnd_resp[%0d]: got %h expected %h", i, resp_data, rsp); end
                repeat ($urandom_range(0, 4)) @(negedge clk);
                resp_ack = 1'b1;
                @(negedge clk);
                resp_ack = 1'b0;
                checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rnd_ack[%0d]: got %b expected 0", i, resp_valid); end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        bit rd, tg;
        logic [31:0] rsp;
        for (int i = 0; i < 260; i++) do_cmd(8'hFF, 8'h00, 24'h000000, rd, rsp, tg);
        checks++; if (err_count !== 8'd255 || int'(err_count) != m_err) begin errors++; $display("FAIL err_saturate: got %0d expected %0d", err_count, m_err); end
`ifndef SPI_CMD_TIMEOUT_EN
        do_cmd(8'h02, 8'h01, 24'h000000, rd, rsp, tg);
        for (int i = 0; i < 260; i++) begin
            drive_packet({8'h01, 8'h01, 24'hFFFFFF});
            @(negedge clk);
            if (m_drop < 255) m_drop++;
        end
        checks++; if (drop_count !== 8'd255 || int'(drop_count) != m_drop) begin errors++; $display("FAIL drop_saturate: got %0d expected %0d", drop_count, m_drop); end
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
        checks++; if (resp_valid !== 1'b0 || cfg_regs !== m_flat()) begin errors++; $display("FAIL drop_saturate_ack: got v=%b regs=%h expected v=0 regs=%h", resp_valid, cfg_regs, m_flat()); end
`endif
    endtask

`ifdef SPI_CMD_TIMEOUT_EN
    task automatic test_timeout();
        bit rd, tg;
        logic [31:0] rsp;
        int cnt;
        do_cmd(8'h02, 8'h02, 24'h000000, rd, rsp, tg);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1) break;
            cnt++;
        end
        if (m_err < 255) m_err++;
        checks++; if (cnt != RESP_TIMEOUT) begin errors++; $display("FAIL timeout_len: got %0d expected %0d", cnt, RESP_TIMEOUT); end
        checks++; if (int'(err_count) != m_err || busy !== 1'b0) begin errors++; $display("FAIL timeout_err: got err=%0d busy=%b expected err=%0d busy=0", err_count, busy, m_err); end
        do_cmd(8'h02, 8'h02, 24'h000000, rd, rsp, tg);
        repeat (RESP_TIMEOUT - 1) @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL timeout_last_cycle: got %b expected 1", resp_valid); end
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
        checks++; if (resp_valid !== 1'b0 || int'(err_count) != m_err) begin errors++; $display("FAIL timeout_ack_wins: got v=%b err=%0d expected v=0 err=%0d", resp_valid, err_count, m_err); end
    endtask
`endif

    task automatic test_reset_mid_resp();
        bit rd, tg;
        logic [31:0] rsp;
        do_cmd(8'h01, 8'h04, 24'hC0FFEE, rd, rsp, tg);
        do_cmd(8'h02, 8'h04, 24'h000000, rd, rsp, tg);
        checks++; if (resp_valid !== 1'b1 || resp_data !== rsp) begin errors++; $display("FAIL pre_reset_read: got v=%b d=%h expected v=1 d=%h", resp_valid, resp_data, rsp); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++; if (cfg_regs !== m_flat() || resp_data !== 32'h0) begin errors++; $display("FAIL midreset_data: got regs=%h d=%h expected 0", cfg_regs, resp_data); end
        checks++; if ({trig, resp_valid, busy, led, err_count, drop_count} !== 20'h0) begin errors++; $display("FAIL midreset_flags: got %h expected 0", {trig, resp_valid, busy, led, err_count, drop_count}); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_trigger_clear();
        test_errors();
        test_drop();
        test_back_to_back();
        test_random();
        test_saturation();
`ifdef SPI_CMD_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
